cic_decim_iq: RTL and testbench
===============================

# cic_decim_iq

Parametrised dual-channel (I/Q) CIC decimator that follows the mixer in the 1-bit AM receive chain. It replaces the single-channel, fixed-order CIC. The block adds a configurable stage count, run-time power-of-two decimation with automatic gain normalisation, rounding with saturation, an input-valid qualifier, and a warm-up/flush state machine on rate change. One shared decimation counter drives both channels, so I and Q outputs are always sample-aligned.

## Interface
- IN_W, 16, input sample width (two's complement)
- OUT_W, 16, output sample width (two's complement, OUT_W ≤ IN_W + STAGES·RMIN_LOG2)
- STAGES, 4, integrator/comb pairs N (1..6); differential delay M = 1
- RMIN_LOG2, 4, log2 of decimation at rate_sel = 0
- CLK  in  1  system clock
- RSTb  in  1  reset; synchronous, active-low, sampled on rising CLK
- rate_sel  in  3  decimation R = 2^(RMIN_LOG2 + rate_sel)
- in_valid  in  1  i_in/q_in valid this cycle
- i_in, q_in  in  IN_W  input samples
- i_out, q_out  out  OUT_W  decimated samples, held between ticks
- out_tick  out  1  one-cycle strobe: i_out/q_out updated this cycle

## Operation
- ACC_W = IN_W + STAGES·(RMIN_LOG2 + 7). All integrators and combs are ACC_W wide. Arithmetic wraps modulo 2^ACC_W, and this wrap is intentional.
- Integrators: on each in_valid, each stage adds the previous stage's output. Stage 0 adds the sign-extended input.
- Decimation counter counts accepted in_valid, 0..R−1. The cycle that accepts the R-th sample (count = R−1) raises a decimation strobe and the counter wraps to 0.
- Combs: fully pipelined, one register per stage. Each stage computes y = x − x_prev and is enabled by the strobe propagating one stage per clock.
- Gain: G = STAGES·(RMIN_LOG2 + rate_q).
  - Output = round(comb_out / 2^(G + IN_W − OUT_W)), round-half-up: add 2^(shift−1), then arithmetic shift.
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- State machine, states FILL and RUN:
  - FILL: comb results are computed but out_tick is suppressed. After STAGES suppressed results, go to RUN.
  - RUN: every comb result produces out_tick.
- Rate change: rate_q is a latched copy of rate_sel. In any cycle where rate_sel ≠ rate_q, the next edge:
  - loads rate_q;
  - clears integrators, comb delays, pipeline strobes and counter;
  - enters FILL.
  - That cycle's in_valid sample is discarded. i_out/q_out hold their last values; out_tick = 0.
- Reset: all state cleared, state = FILL, rate_q = rate_sel. i_out = q_out = 0, out_tick = 0.
- RSTb low takes priority over rate change and in_valid.

## Timing
- Latency: out_tick rises STAGES + 2 cycles after the edge that samples the R-th in_valid. That is STAGES comb stages, plus 1 round/saturate register, plus 1 capture.
- in_valid may be asserted every cycle. R ≥ 16 > STAGES + 2 guarantees the comb pipeline never overlaps.
- in_valid gaps of any length only stall the integrators and counter. An in-flight comb pipeline completes regardless.
- out_tick never asserts on two consecutive cycles.

## Structure
- Package cic_pkg holds:
  - function acc_w(IN_W, STAGES, RMIN_LOG2);
  - state enum {FILL, RUN};
  - rate-width constant 3.
- Sub-module cic_chan: integrators, comb pipeline and round/saturate for one channel. It is instantiated for I and Q.
- The top level owns the counter, rate_q, the FSM and the strobe shift register, which are shared by both channels.
- Target size: ~250 lines total.

## Test plan
- Reset, then rate_sel = 0, in_valid = 1 continuously, i_in = 0x1000, q_in = 0xF000:
  - first out_tick only after 5·16 valid samples (4 suppressed);
  - all outputs are exactly i_out = 0x1000, q_out = 0xF000.
- Full scale, rate_sel = 7:
  - i_in = 0x7FFF settles to i_out = 0x7FFF;
  - i_in = 0x8000 settles to i_out = 0x8000;
  - no wrap artefacts.
- Latency check, rate_sel = 0:
  - count cycles from the 16th valid sample to out_tick; must be exactly STAGES + 2 = 6;
  - repeat with in_valid asserted 1-in-3 cycles; ticks every 48 cycles, values unchanged.
- Rate change 0→2 mid-stream with DC 0x0800:
  - no out_tick for 4·64 valid samples after the change;
  - outputs held at 0x0800 meanwhile, then resume at 0x0800.
- Synchronous reset pulsed low mid-decimation, with a comb strobe in flight:
  - out_tick stays 0 and i_out = q_out = 0 at the next edge;
  - RSTb low during the in-flight strobe cycle cancels that tick;
  - afterwards the FILL behaviour repeats.
- I/Q alignment: random i_in/q_in against a bit-accurate reference model; every out_tick matches both channels exactly.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and sizing helpers for the dual-channel CIC decimator.
package cic_pkg;

    // rate_sel / rate_q width; decimation spans 2^RMIN_LOG2 .. 2^(RMIN_LOG2+7)
    localparam int RATE_W = 3;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } cic_state_t;

    // Accumulator width covering the worst-case bit growth at the slowest rate
    function automatic int acc_w(input int in_w, input int stages, input int rmin_log2);
        return in_w + stages * (rmin_log2 + (1 << RATE_W) - 1);
    endfunction

endpackage

// File: rtl/cic_chan.sv
// One CIC channel: integrator cascade, strobe-driven comb pipeline and
// round-half-up / saturate output register. Control comes from the top level.
module cic_chan
    import cic_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 16,
    parameter int STAGES    = 4,
    parameter int RMIN_LOG2 = 4,
    parameter int ACC_W     = acc_w(IN_W, STAGES, RMIN_LOG2)
) (
    input  logic              CLK,
    input  logic              RSTb,
    input  logic              clr,
    input  logic              in_en,
    input  logic [STAGES:0]   stb,
    input  logic [RATE_W-1:0] rate_q,
    input  logic [IN_W-1:0]   x_in,
    output logic [OUT_W-1:0]  y_rnd
);

    localparam int SH_W = 8;
    localparam logic signed [ACC_W:0] ONE     = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [ACC_W-1:0] integ   [STAGES];
    logic [ACC_W-1:0] comb    [STAGES];
    logic [ACC_W-1:0] dly     [STAGES];
    logic [ACC_W-1:0] comb_in [STAGES];
    logic [ACC_W-1:0] x_ext;

    logic [SH_W-1:0]         shift;
    logic signed [ACC_W:0]   c_ext;
    logic signed [ACC_W:0]   half;
    logic signed [ACC_W:0]   biased;
    logic signed [ACC_W:0]   shifted;
    logic [OUT_W-1:0]        sat_val;

    assign x_ext = {{(ACC_W-IN_W){x_in[IN_W-1]}}, x_in};

    // Integrators: each stage adds the registered output of the stage before;
    // modular wrap is harmless because the combs undo it exactly.
    always_ff @(posedge CLK) begin
        if (!RSTb || clr) begin
            for (int k = 0; k < STAGES; k++) integ[k] <= '0;
        end else if (in_en) begin
            integ[0] <= integ[0] + x_ext;
            for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // Comb inputs: stage 0 takes the last integrator, later stages chain
    always_comb begin
        comb_in[0] = integ[STAGES-1];
        for (int k = 1; k < STAGES; k++) comb_in[k] = comb[k-1];
    end

    // Comb pipeline: stage k fires when the decimation strobe reaches it
    always_ff @(posedge CLK) begin
        if (!RSTb || clr) begin
            for (int k = 0; k < STAGES; k++) begin
                comb[k] <= '0;
                dly[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (stb[k]) begin
                    comb[k] <= comb_in[k] - dly[k];
                    dly[k]  <= comb_in[k];
                end
            end
        end
    end

    // Gain normalisation: shift follows the latched rate, then round and clamp
    always_comb begin
        shift   = SH_W'(STAGES * (RMIN_LOG2 + int'(rate_q)) + IN_W - OUT_W);
        c_ext   = signed'({comb[STAGES-1][ACC_W-1], comb[STAGES-1]});
        half    = '0;
        if (shift != '0) half = ONE << (shift - SH_W'(1));
        biased  = c_ext + half;
        shifted = biased >>> shift;
        if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
        else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
        else                        sat_val = shifted[OUT_W-1:0];
    end

    // Round/saturate register, loaded one stage after the last comb
    always_ff @(posedge CLK) begin
        if (!RSTb || clr)      y_rnd <= '0;
        else if (stb[STAGES])  y_rnd <= sat_val;
    end

endmodule

// File: rtl/cic_decim_iq.sv
// Dual-channel (I/Q) CIC decimator. Owns the shared decimation counter, the
// latched rate, the warm-up FSM and the strobe shift register so both
// channels always produce sample-aligned outputs.
//
// state | meaning
// FILL  | comb results computed but discarded until the filter memory is valid
// RUN   | every comb result is captured and flagged with out_tick
module cic_decim_iq
    import cic_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 16,
    parameter int STAGES    = 4,
    parameter int RMIN_LOG2 = 4
) (
    input  logic              CLK,
    input  logic              RSTb,
    input  logic [RATE_W-1:0] rate_sel,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   i_in,
    input  logic [IN_W-1:0]   q_in,
    output logic [OUT_W-1:0]  i_out,
    output logic [OUT_W-1:0]  q_out,
    output logic              out_tick
);

    localparam int ACC_W = acc_w(IN_W, STAGES, RMIN_LOG2);
    localparam int CNT_W = RMIN_LOG2 + (1 << RATE_W) - 1;
    localparam int FC_W  = 3;
    localparam logic [RATE_W-1:0] RATE_MAX = '1;

    logic [RATE_W-1:0] rate_q;
    logic              rate_chg;
    logic              accept;
    logic              cnt_last;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_max;
    logic [STAGES+1:0] stb;
    cic_state_t        state;
    logic [FC_W-1:0]   fill_cnt;
    logic [OUT_W-1:0]  i_rnd;
    logic [OUT_W-1:0]  q_rnd;
    logic              cap;

    assign rate_chg = (rate_sel != rate_q);
    assign accept   = in_valid && !rate_chg;
    assign cnt_max  = {CNT_W{1'b1}} >> (RATE_MAX - rate_q);
    assign cnt_last = (cnt == cnt_max);
    assign cap      = stb[STAGES+1] && (state == RUN);

    // Latched rate; a mismatch restarts the whole filter on the next edge
    always_ff @(posedge CLK) begin
        if (!RSTb)         rate_q <= rate_sel;
        else if (rate_chg) rate_q <= rate_sel;
    end

    // Decimation counter over accepted samples, wrapping at R-1
    always_ff @(posedge CLK) begin
        if (!RSTb || rate_chg) cnt <= '0;
        else if (accept)       cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
    end

    // Strobe shift register: bit k enables comb k, then round, then capture
    always_ff @(posedge CLK) begin
        if (!RSTb || rate_chg) stb <= '0;
        else                   stb <= {stb[STAGES:0], accept && cnt_last};
    end

    // Warm-up FSM: discard STAGES results after reset or a rate change
    always_ff @(posedge CLK) begin
        if (!RSTb || rate_chg) begin
            state    <= FILL;
            fill_cnt <= FC_W'(STAGES - 1);
        end else if (stb[STAGES+1] && state == FILL) begin
            if (fill_cnt == '0) state <= RUN;
            else                fill_cnt <= fill_cnt - FC_W'(1);
        end
    end

    // Output capture; outputs hold through FILL and across rate changes
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            i_out    <= '0;
            q_out    <= '0;
            out_tick <= 1'b0;
        end else if (rate_chg) begin
            out_tick <= 1'b0;
        end else begin
            out_tick <= cap;
            if (cap) begin
                i_out <= i_rnd;
                q_out <= q_rnd;
            end
        end
    end

    cic_chan #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .STAGES    (STAGES),
        .RMIN_LOG2 (RMIN_LOG2),
        .ACC_W     (ACC_W)
    ) u_chan_i (
        .CLK    (CLK),
        .RSTb   (RSTb),
        .clr    (rate_chg),
        .in_en  (accept),
        .stb    (stb[STAGES:0]),
        .rate_q (rate_q),
        .x_in   (i_in),
        .y_rnd  (i_rnd)
    );

    cic_chan #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .STAGES    (STAGES),
        .RMIN_LOG2 (RMIN_LOG2),
        .ACC_W     (ACC_W)
    ) u_chan_q (
        .CLK    (CLK),
        .RSTb   (RSTb),
        .clr    (rate_chg),
        .in_en  (accept),
        .stb    (stb[STAGES:0]),
        .rate_q (rate_q),
        .x_in   (q_in),
        .y_rnd  (q_rnd)
    );

endmodule

// File: tb/tb_cic_decim_iq.sv
// Self-checking bench for cic_decim_iq: reference model feeds a scoreboard of
// expected ticks; DC vector table plus reset / rate-change / random sequences.
module tb_cic_decim_iq;

    localparam int IN_W      = 16;
    localparam int OUT_W     = 16;
    localparam int STAGES    = 4;
    localparam int RMIN_LOG2 = 4;
    localparam int ACC_W     = IN_W + STAGES * (RMIN_LOG2 + 7);
    localparam int LAT       = STAGES + 2;

    logic             CLK = 1'b0;
    logic             RSTb = 1'b0;
    logic [2:0]       rate_sel = 3'd0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  i_in = '0;
    logic [IN_W-1:0]  q_in = '0;
    logic [OUT_W-1:0] i_out;
    logic [OUT_W-1:0] q_out;
    logic             out_tick;

    always #5 CLK = ~CLK;

    cic_decim_iq #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .STAGES    (STAGES),
        .RMIN_LOG2 (RMIN_LOG2)
    ) dut (
        .CLK      (CLK),
        .RSTb     (RSTb),
        .rate_sel (rate_sel),
        .in_valid (in_valid),
        .i_in     (i_in),
        .q_in     (q_in),
        .i_out    (i_out),
        .q_out    (q_out),
        .out_tick (out_tick)
    );

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        int          due;
    } exp_t;

    typedef struct {
        logic [2:0]  rate;
        logic [15:0] i;
        logic [15:0] q;
        int          period;
        logic [15:0] exp_i;
        logic [15:0] exp_q;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ticks = 0;
    int   last_tick_cyc = 0;
    int   prev_tick_cyc = 0;
    logic tick_d = 1'b0;

    // reference model state
    logic [ACC_W-1:0] m_int [2][STAGES];
    logic [ACC_W-1:0] m_dly [2][STAGES];
    int               m_cnt;
    int               m_fill;
    logic [2:0]       m_rate;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] m_round(input logic [ACC_W-1:0] c, input int sh);
        longint v;
        longint r;
        v = longint'(signed'(c));
        r = (v + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic m_clear(input logic [2:0] rs);
        for (int ch = 0; ch < 2; ch++)
            for (int k = 0; k < STAGES; k++) begin
                m_int[ch][k] = '0;
                m_dly[ch][k] = '0;
            end
        m_cnt  = 0;
        m_fill = STAGES;
        m_rate = rs;
        sb.delete();
    endtask

    task automatic m_edge(input logic rst_n, input logic v, input logic [2:0] rs,
                          input logic [15:0] xi, input logic [15:0] xq);
        logic [ACC_W-1:0] c;
        logic [ACC_W-1:0] y;
        logic [15:0]      x [2];
        logic [15:0]      r [2];
        exp_t             e;
        int               rr;
        if (!rst_n || rs != m_rate) begin
            m_clear(rs);
            return;
        end
        if (!v) return;
        x[0] = xi;
        x[1] = xq;
        rr = 1 << (RMIN_LOG2 + int'(m_rate));
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = STAGES - 1; k >= 1; k--) m_int[ch][k] = m_int[ch][k] + m_int[ch][k-1];
            m_int[ch][0] = m_int[ch][0] + {{(ACC_W-16){x[ch][15]}}, x[ch]};
        end
        if (m_cnt == rr - 1) begin
            m_cnt = 0;
            for (int ch = 0; ch < 2; ch++) begin
                c = m_int[ch][STAGES-1];
                for (int k = 0; k < STAGES; k++) begin
                    y = c - m_dly[ch][k];
                    m_dly[ch][k] = c;
                    c = y;
                end
                r[ch] = m_round(c, STAGES * (RMIN_LOG2 + int'(m_rate)) + IN_W - OUT_W);
            end
            if (m_fill > 0) m_fill--;
            else begin
                e.i = r[0];
                e.q = r[1];
                e.due = cyc + LAT;
                sb.push_back(e);
            end
        end else begin
            m_cnt++;
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // tick monitor: pop scoreboard, check timing and values
    always @(negedge CLK) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            check("missing_tick", cyc, sb[0].due);
            void'(sb.pop_front());
        end
        if (out_tick) begin
            ticks++;
            prev_tick_cyc = last_tick_cyc;
            last_tick_cyc = cyc;
            check("tick_spacing", tick_d, 0);
            if (sb.size() == 0) begin
                check("spurious_tick", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("tick_latency", cyc, e.due);
                check("sb_i_out", i_out, e.i);
                check("sb_q_out", q_out, e.q);
            end
        end
        tick_d = out_tick;
    end

    task automatic step(input logic v, input logic [15:0] xi, input logic [15:0] xq);
        in_valid = v;
        i_in = xi;
        q_in = xq;
        @(posedge CLK);
        #1;
        m_edge(RSTb, v, rate_sel, xi, xq);
    endtask

    task automatic drive_dc(input int n, input int period, input logic [15:0] xi, input logic [15:0] xq);
        for (int s = 0; s < n; s++) begin
            repeat (period - 1) step(1'b0, xi, xq);
            step(1'b1, xi, xq);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, ticks=%0d", ticks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   t0;
        int   base;
        int   n;
        int   rr;
        int   exp_ticks;
        logic found;
        logic vv;

        vt[0] = '{3'd0, 16'h1000, 16'hF000, 1, 16'h1000, 16'hF000};
        vt[1] = '{3'd7, 16'h7FFF, 16'h8000, 1, 16'h7FFF, 16'h8000};
        vt[2] = '{3'd7, 16'h8000, 16'h7FFF, 1, 16'h8000, 16'h7FFF};
        vt[3] = '{3'd0, 16'h1000, 16'hF000, 3, 16'h1000, 16'hF000};
        vt[4] = '{3'd2, 16'h0800, 16'hF800, 1, 16'h0800, 16'hF800};
        vt[5] = '{3'd1, 16'hFFFF, 16'h0001, 2, 16'hFFFF, 16'h0001};

        // reset
        RSTb = 1'b0;
        rate_sel = 3'd0;
        step(1'b0, 16'h0, 16'h0);
        step(1'b1, 16'h1234, 16'h5678);
        check("rst_i_out", i_out, 0);
        check("rst_q_out", q_out, 0);
        check("rst_tick", out_tick, 0);
        RSTb = 1'b1;

        // first tick after 5*R samples, exact latency
        drive_dc(79, 1, 16'h1000, 16'hF000);
        check("no_early_tick", ticks, 0);
        drive_dc(1, 1, 16'h1000, 16'hF000);
        t0 = cyc;
        n = 0;
        while (ticks == 0 && n < 20) begin
            step(1'b1, 16'h1000, 16'hF000);
            n++;
        end
        check("first_tick_latency", last_tick_cyc - t0, LAT);
        check("first_i_out", i_out, 16'h1000);
        check("first_q_out", q_out, 16'hF000);

        // DC vector table
        for (int v = 0; v < 6; v++) begin
            exp_ticks = 6;
            if (vt[v].rate != rate_sel) begin
                rate_sel = vt[v].rate;
                step(1'b0, vt[v].i, vt[v].q);
                exp_ticks = 2;
            end
            rr = 1 << (RMIN_LOG2 + int'(vt[v].rate));
            base = ticks;
            drive_dc(6 * rr, vt[v].period, vt[v].i, vt[v].q);
            repeat (LAT + 4) step(1'b0, vt[v].i, vt[v].q);
            check($sformatf("vec%0d_i", v), i_out, vt[v].exp_i);
            check($sformatf("vec%0d_q", v), q_out, vt[v].exp_q);
            check($sformatf("vec%0d_ticks", v), ticks - base, exp_ticks);
            check($sformatf("vec%0d_gap", v), last_tick_cyc - prev_tick_cyc, rr * vt[v].period);
        end

        // rate change 0 -> 2 mid-stream
        rate_sel = 3'd0;
        step(1'b0, 16'h0800, 16'h0800);
        drive_dc(6 * 16 + 5, 1, 16'h0800, 16'h0800);
        check("rc_pre_i", i_out, 16'h0800);
        base = ticks;
        rate_sel = 3'd2;
        step(1'b1, 16'h0800, 16'h0800);
        drive_dc(4 * 64 + 20, 1, 16'h0800, 16'h0800);
        check("rc_no_tick", ticks, base);
        check("rc_hold_i", i_out, 16'h0800);
        check("rc_hold_q", q_out, 16'h0800);
        drive_dc(44, 1, 16'h0800, 16'h0800);
        repeat (LAT + 2) step(1'b1, 16'h0800, 16'h0800);
        check("rc_resume", ticks, base + 1);
        check("rc_resume_i", i_out, 16'h0800);

        // synchronous reset with a comb strobe in flight
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            step(1'b1, 16'h0800, 16'h0800);
            if (sb.size() > 0) found = 1'b1;
            n++;
        end
        check("strobe_found", found, 1);
        step(1'b1, 16'h0800, 16'h0800);
        step(1'b1, 16'h0800, 16'h0800);
        RSTb = 1'b0;
        step(1'b1, 16'h0800, 16'h0800);
        check("midrst_tick", out_tick, 0);
        check("midrst_i", i_out, 0);
        check("midrst_q", q_out, 0);
        RSTb = 1'b1;
        base = ticks;
        drive_dc(5 * 64, 1, 16'h0800, 16'h0800);
        check("refill_no_tick", ticks, base);
        repeat (LAT + 1) step(1'b1, 16'h0800, 16'h0800);
        check("refill_tick", ticks, base + 1);
        check("refill_i", i_out, 16'h0800);

        // random I/Q with random gaps against the model
        rate_sel = 3'd0;
        step(1'b0, 16'h0, 16'h0);
        for (int s = 0; s < 500; s++) begin
            vv = ($urandom_range(0, 3) != 0);
            step(vv, 16'($urandom), 16'($urandom));
        end
        repeat (LAT + 4) step(1'b0, 16'h0, 16'h0);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
